// File: rtl/sd_spi_cmd_engine.sv
// SD SPI-mode command engine: frames one command with CRC7, polls for R1, optionally collects R3/R7 payload.
// Latency: (PRE_FILL + 6 + polls + [4] + POST_FILL) byte transfers, each transfer time + 1 cycle; resp_valid 1 cycle after last xfer_done.
// Backpressure: cmd_ready only in IDLE; byte chaining paced entirely by xfer_done from the SPI controller.
module sd_spi_cmd_engine #(
   parameter int PRE_FILL     = 1,
   parameter int POST_FILL    = 1,
   parameter int RESP_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic        resp_long,
   input  logic        keep_cs,
   input  logic        cs_release,
   output logic        resp_valid,
   output logic [7:0]  resp_r1,
   output logic [31:0] resp_data,
   output logic        resp_timeout,
   output logic        busy,
   output logic        cs_n,
   output logic        xfer_start,
   output logic [7:0]  xfer_tx,
   input  logic        xfer_done,
   input  logic [7:0]  xfer_rx
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_CMD, S_POLL, S_PAYLOAD, S_POST} state_t;

   state_t      state, state_nxt, after_resp;
   logic        outst;
   logic        done_acc;
   logic        accept;
   logic [7:0]  cnt;
   logic [39:0] frame;
   logic [6:0]  crc, crc_nxt;
   logic        long_q, keep_q;

   // CRC7 (x^7 + x^3 + 1) advanced by one byte, MSB first
   function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] b);
      logic [6:0] r;
      logic       fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[6] ^ b[i];
         r  = {r[5:0], 1'b0};
         if (fb) r = r ^ 7'h09;
      end
      return r;
   endfunction

   // Only a done that answers our own outstanding start is acted on
   assign done_acc  = xfer_done & outst;
   assign accept    = cmd_valid & (state == S_IDLE);
   assign cmd_ready = (state == S_IDLE);
   assign busy      = ~cmd_ready;
   assign crc_nxt   = crc7_byte(crc, xfer_tx);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state: each phase advances on the accepted done of its last byte
   always_comb begin
      state_nxt  = state;
      after_resp = (keep_q || POST_FILL == 0) ? S_IDLE : S_POST;
      case (state)
         S_IDLE:    if (accept) state_nxt = (PRE_FILL == 0) ? S_CMD : S_PRE;
         S_PRE:     if (done_acc && cnt == 8'(PRE_FILL - 1)) state_nxt = S_CMD;
         S_CMD:     if (done_acc && cnt == 8'd5) state_nxt = S_POLL;
         S_POLL: begin
            if (done_acc) begin
               if (!xfer_rx[7])                          state_nxt = long_q ? S_PAYLOAD : after_resp;
               else if (cnt == 8'(RESP_TIMEOUT - 1))     state_nxt = after_resp;
            end
         end
         S_PAYLOAD: if (done_acc && cnt == 8'd3) state_nxt = after_resp;
         S_POST:    if (done_acc && cnt == 8'(POST_FILL - 1)) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Datapath: byte sequencing, CRC, response capture, chip select
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_n         <= 1'b1;
         xfer_start   <= 1'b0;
         xfer_tx      <= 8'hFF;
         outst        <= 1'b0;
         cnt          <= 8'd0;
         frame        <= 40'd0;
         crc          <= 7'd0;
         long_q       <= 1'b0;
         keep_q       <= 1'b0;
         resp_valid   <= 1'b0;
         resp_r1      <= 8'hFF;
         resp_data    <= 32'd0;
         resp_timeout <= 1'b0;
      end else begin
         xfer_start <= 1'b0;
         resp_valid <= 1'b0;

         if (xfer_start)    outst <= 1'b1;
         else if (done_acc) outst <= 1'b0;

         if (state_nxt != state) cnt <= 8'd0;
         else if (done_acc)      cnt <= cnt + 8'd1;

         // Next byte starts the cycle after the previous one finished
         if (done_acc && state_nxt != S_IDLE) xfer_start <= 1'b1;
         if (state != S_IDLE && state_nxt == S_IDLE) resp_valid <= 1'b1;

         // Response complete without keep_cs: deselect card before post-fill
         if ((state == S_POLL || state == S_PAYLOAD) &&
             (state_nxt == S_POST || state_nxt == S_IDLE) && !keep_q)
            cs_n <= 1'b1;

         case (state)
            S_IDLE: begin
               if (accept) begin
                  frame        <= {2'b01, cmd_index, cmd_arg};
                  long_q       <= resp_long;
                  keep_q       <= keep_cs;
                  crc          <= 7'd0;
                  resp_r1      <= 8'hFF;
                  resp_data    <= 32'd0;
                  resp_timeout <= 1'b0;
                  cs_n         <= 1'b0;
                  xfer_start   <= 1'b1;
                  xfer_tx      <= (PRE_FILL == 0) ? {2'b01, cmd_index} : 8'hFF;
               end else if (cs_release) begin
                  cs_n <= 1'b1;
               end
            end
            S_PRE: begin
               if (done_acc && state_nxt == S_CMD) xfer_tx <= frame[39:32];
            end
            S_CMD: begin
               if (done_acc) begin
                  if (cnt == 8'd5) begin
                     xfer_tx <= 8'hFF;
                  end else if (cnt == 8'd4) begin
                     crc     <= crc_nxt;
                     xfer_tx <= {crc_nxt, 1'b1};
                  end else begin
                     crc     <= crc_nxt;
                     frame   <= {frame[31:0], 8'h00};
                     xfer_tx <= frame[31:24];
                  end
               end
            end
            S_POLL: begin
               if (done_acc && !xfer_rx[7])          resp_r1      <= xfer_rx;
               else if (done_acc && state_nxt != S_POLL) resp_timeout <= 1'b1;
            end
            S_PAYLOAD: begin
               if (done_acc) resp_data <= {resp_data[23:0], xfer_rx};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Bench for sd_spi_cmd_engine: directed SD commands plus randomized ones against a transaction-level model.
// Latency: SPI controller model answers each start after 1..4 cycles.
// Backpressure: checks byte chaining spacing, cmd_ready while busy, and abort by reset.
module tb_sd_spi_cmd_engine;

   localparam int PRE  = 1;
   localparam int POST = 1;
   localparam int TMO  = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [5:0]  cmd_index = 6'd0;
   logic [31:0] cmd_arg = 32'd0;
   logic        resp_long = 1'b0;
   logic        keep_cs = 1'b0;
   logic        cs_release = 1'b0;
   logic        resp_valid;
   logic [7:0]  resp_r1;
   logic [31:0] resp_data;
   logic        resp_timeout;
   logic        busy;
   logic        cs_n;
   logic        xfer_start;
   logic [7:0]  xfer_tx;
   logic        xfer_done;
   logic [7:0]  xfer_rx;

   logic        resp_done = 1'b0;
   logic        stray_done = 1'b0;
   logic [7:0]  resp_rx = 8'hFF;

   assign xfer_done = resp_done | stray_done;
   assign xfer_rx   = resp_rx;

   int checks = 0;
   int errors = 0;
   int gen = 0;

   logic [7:0]  exp_tx[$];
   bit          exp_cs[$];
   logic [7:0]  rx_plan[$];
   logic [7:0]  tx_log[$];
   logic [7:0]  exp_r1;
   logic [31:0] exp_data;
   bit          exp_to;

   sd_spi_cmd_engine #(.PRE_FILL(PRE), .POST_FILL(POST), .RESP_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_long(resp_long), .keep_cs(keep_cs),
      .cs_release(cs_release), .resp_valid(resp_valid), .resp_r1(resp_r1),
      .resp_data(resp_data), .resp_timeout(resp_timeout), .busy(busy), .cs_n(cs_n),
      .xfer_start(xfer_start), .xfer_tx(xfer_tx), .xfer_done(xfer_done), .xfer_rx(xfer_rx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference CRC7 over the 40-bit command header, bit by bit
   function automatic logic [6:0] ref_crc7(input logic [39:0] f);
      logic [6:0] c;
      logic       fb;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb = c[6] ^ f[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   // SPI controller model: logs every byte, answers from rx_plan after a random delay
   int         cyc = 0;
   int         seen_gen = 0;
   int         nx = 0;
   int         lat = 0;
   int         last_done = 0;
   bit         pend = 1'b0;
   bit         first = 1'b1;
   logic [7:0] cur_tx = 8'hFF;

   always @(negedge clk) begin
      cyc++;
      resp_done = 1'b0;
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (gen != seen_gen) begin
            seen_gen = gen;
            nx = 0;
            tx_log.delete();
            first = 1'b1;
            pend = 1'b0;
         end
         if (pend) begin
            chk("tx_stable", 32'(xfer_tx), 32'(cur_tx));
            if (lat == 0) begin
               resp_done = 1'b1;
               resp_rx   = (nx - 1 < rx_plan.size()) ? rx_plan[nx - 1] : 8'hFF;
               pend      = 1'b0;
               last_done = cyc;
            end else begin
               lat--;
            end
         end
         if (xfer_start) begin
            if (!first) chk("start_spacing", 32'(cyc - last_done), 32'd1);
            first = 1'b0;
            chk("cs_n_at_start", 32'(cs_n), 32'((nx < exp_cs.size()) ? exp_cs[nx] : 1'b1));
            tx_log.push_back(xfer_tx);
            cur_tx = xfer_tx;
            nx++;
            pend = 1'b1;
            lat = $urandom_range(0, 3);
         end
      end
   end

   // Expected byte streams and response for one command
   task automatic build_plan(input logic [5:0] idx, input logic [31:0] arg, input bit lng,
                             input bit keep, input int k, input logic [7:0] r1, input logic [31:0] pl);
      logic [39:0] f;
      int          npoll;
      bit          to;
      exp_tx.delete(); exp_cs.delete(); rx_plan.delete();
      f = {2'b01, idx, arg};
      for (int i = 0; i < PRE; i++) begin
         exp_tx.push_back(8'hFF); exp_cs.push_back(1'b0); rx_plan.push_back(8'hFF);
      end
      for (int i = 0; i < 5; i++) begin
         exp_tx.push_back(f[39 - 8*i -: 8]); exp_cs.push_back(1'b0); rx_plan.push_back(8'hFF);
      end
      exp_tx.push_back({ref_crc7(f), 1'b1}); exp_cs.push_back(1'b0); rx_plan.push_back(8'hFF);
      to    = (k == 0);
      npoll = to ? TMO : k;
      for (int p = 1; p <= npoll; p++) begin
         exp_tx.push_back(8'hFF); exp_cs.push_back(1'b0);
         rx_plan.push_back((!to && p == k) ? r1 : (8'h80 | 8'($urandom_range(0, 127))));
      end
      if (lng && !to)
         for (int i = 0; i < 4; i++) begin
            exp_tx.push_back(8'hFF); exp_cs.push_back(1'b0); rx_plan.push_back(pl[31 - 8*i -: 8]);
         end
      if (!keep)
         for (int i = 0; i < POST; i++) begin
            exp_tx.push_back(8'hFF); exp_cs.push_back(1'b1); rx_plan.push_back(8'hFF);
         end
      exp_r1   = to ? 8'hFF : r1;
      exp_data = (lng && !to) ? pl : 32'd0;
      exp_to   = to;
   endtask

   task automatic drive_accept(input logic [5:0] idx, input logic [31:0] arg, input bit lng,
                               input bit keep, input bit rel);
      @(negedge clk);
      cmd_index = idx; cmd_arg = arg; resp_long = lng; keep_cs = keep;
      cs_release = rel; cmd_valid = 1'b1; gen++;
      @(negedge clk);
      cs_release = 1'b0;
      chk("accept_cs_n", 32'(cs_n), 32'd0);
      chk("accept_start", 32'(xfer_start), 32'd1);
      chk("accept_busy", 32'(busy), 32'd1);
   endtask

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit lng, input bit keep,
                          input int k, input logic [7:0] r1, input logic [31:0] pl,
                          input bit chk_crc, input logic [7:0] crcb, input bit hold, input bit rel);
      bit got;
      build_plan(idx, arg, lng, keep, k, r1, pl);
      drive_accept(idx, arg, lng, keep, rel);
      if (hold) begin
         for (int i = 0; i < 500; i++) begin
            if (tx_log.size() >= 6) break;
            chk("ready_low_busy", 32'(cmd_ready), 32'd0);
            @(negedge clk);
         end
      end
      cmd_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (resp_valid) begin got = 1'b1; break; end
      end
      chk("resp_valid_seen", 32'(got), 32'd1);
      if (got) begin
         chk("ready_at_done", 32'(cmd_ready), 32'd1);
         chk("resp_r1", 32'(resp_r1), 32'(exp_r1));
         chk("resp_data", resp_data, exp_data);
         chk("resp_timeout", 32'(resp_timeout), 32'(exp_to));
         chk("cs_n_after", 32'(cs_n), keep ? 32'd0 : 32'd1);
         chk("xfer_count", 32'(tx_log.size()), 32'(exp_tx.size()));
         for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            chk("tx_byte", {24'd0, tx_log[i]}, {24'd0, exp_tx[i]});
         if (chk_crc && tx_log.size() > PRE + 5)
            chk("crc_byte", 32'(tx_log[PRE + 5]), 32'(crcb));
         repeat (3) @(negedge clk);
         chk("no_extra_xfer", 32'(tx_log.size()), 32'(exp_tx.size()));
         chk("resp_r1_held", 32'(resp_r1), 32'(exp_r1));
         chk("resp_valid_pulse", 32'(resp_valid), 32'd0);
      end
   endtask

   initial begin
      bit seen;
      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_start", 32'(xfer_start), 32'd0);
      chk("rst_tx", 32'(xfer_tx), 32'hFF);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_r1", 32'(resp_r1), 32'hFF);
      chk("rst_data", resp_data, 32'd0);
      chk("rst_timeout", 32'(resp_timeout), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // CMD0, CMD8 long, CMD55 timeout with cmd_valid held while busy
      run_cmd(6'd0,  32'd0,     1'b0, 1'b0, 2, 8'h01, 32'd0,        1'b1, 8'h95, 1'b0, 1'b0);
      run_cmd(6'd8,  32'h1AA,   1'b1, 1'b0, 1, 8'h01, 32'h000001AA, 1'b1, 8'h87, 1'b0, 1'b0);
      run_cmd(6'd55, 32'd0,     1'b0, 1'b0, 0, 8'h00, 32'd0,        1'b1, 8'h65, 1'b1, 1'b0);

      // Spurious done while idle
      @(negedge clk); stray_done = 1'b1;
      @(negedge clk); stray_done = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (xfer_start || resp_valid || !cmd_ready) seen = 1'b1;
      end
      chk("idle_stray_done", 32'(seen), 32'd0);

      // keep_cs holds select; cs_release drops it next cycle
      run_cmd(6'd17, 32'h1000, 1'b0, 1'b1, 3, 8'h00, 32'd0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("keep_cs_low", 32'(cs_n), 32'd0);
      cs_release = 1'b1;
      @(negedge clk); cs_release = 1'b0;
      chk("cs_release", 32'(cs_n), 32'd1);

      // Accept wins over a simultaneous cs_release
      run_cmd(6'd17, 32'h2000, 1'b0, 1'b1, 1, 8'h00, 32'd0, 1'b0, 8'h00, 1'b0, 1'b0);
      run_cmd(6'd18, 32'h3000, 1'b0, 1'b0, 2, 8'h00, 32'd0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Reset during CMD byte 3 aborts at once
      build_plan(6'd0, 32'd0, 1'b0, 1'b0, 1, 8'h01, 32'd0);
      drive_accept(6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      cmd_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (tx_log.size() == PRE + 4) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      chk("reached_cmd_byte3", 32'(seen), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_cs_n", 32'(cs_n), 32'd1);
      chk("abort_start", 32'(xfer_start), 32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); stray_done = 1'b1;
      @(negedge clk); stray_done = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (xfer_start || !cs_n || !cmd_ready) seen = 1'b1;
      end
      chk("abort_stray_done", 32'(seen), 32'd0);
      run_cmd(6'd0, 32'd0, 1'b0, 1'b0, 1, 8'h01, 32'd0, 1'b1, 8'h95, 1'b0, 1'b0);

      // Randomized commands against the model
      for (int n = 0; n < 12; n++) begin
         run_cmd(6'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, TMO),
                 8'($urandom_range(0, 127)), $urandom, 1'b0, 8'h00, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
